fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch unit for the RV32I core, sitting between the unified memory controller and decode/issue. Fetches one instruction word per memory transaction into a circular fetch queue. Hands instructions and their PCs to the core with a valid/ready handshake. Accepts a redirect from the core that flushes all fetched and in-flight state.

---
 rtl/fetch_queue_unit.sv | 139 +++++++++++++
 tb/tb_fetch_queue_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: single-outstanding memory fetcher feeding a circular queue of {ins, pc, pred}.
// Optional JAL target following is enabled by defining IFQ_JAL_PRED_EN.
module fetch_queue_unit #(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        ins_valid_o,
    input  logic        ins_ready_i,
    output logic [31:0] ins_o,
    output logic [31:0] pc_o,
    output logic        pred_jump_o
);
    localparam int          PW      = $clog2(QDEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(QDEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        r_state;
    logic          r_mem_req;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_fetch_pc;
    logic          r_drop;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic [31:0]   r_q_ins [QDEPTH];
    logic [31:0]   r_q_pc  [QDEPTH];

    logic          w_push;
    logic          w_pop;
    logic          w_space;
    logic [31:0]   w_next_pc;

    assign ins_valid_o = (r_count != '0);
    assign w_space     = (r_count < DEPTH_C);
    // A response is only queued when it belongs to the current fetch stream.
    assign w_push      = (r_state == WAIT) && mem_valid_i && !r_drop && !redirect_i;
    assign w_pop       = ins_valid_o && ins_ready_i && !redirect_i;

    assign mem_req_o   = r_mem_req;
    assign mem_addr_o  = r_mem_addr;
    assign ins_o       = ins_valid_o ? r_q_ins[r_head] : 32'h0;
    assign pc_o        = ins_valid_o ? r_q_pc[r_head]  : 32'h0;

`ifdef IFQ_JAL_PRED_EN
    logic          r_q_pred [QDEPTH];
    logic          w_is_jal;
    logic [31:0]   w_jal_imm;

    assign w_is_jal  = (mem_data_i[6:0] == 7'b1101111);
    assign w_jal_imm = {{11{mem_data_i[31]}}, mem_data_i[31], mem_data_i[19:12],
                        mem_data_i[20], mem_data_i[30:21], 1'b0};
    assign w_next_pc = w_is_jal ? (r_fetch_pc + w_jal_imm) : (r_fetch_pc + 32'd4);
    assign pred_jump_o = ins_valid_o & r_q_pred[r_head];

    always_ff @(posedge clk) begin
        if (!rst && rdy && w_push)
            r_q_pred[r_tail] <= w_is_jal;
    end
`else
    assign w_next_pc   = r_fetch_pc + 32'd4;
    assign pred_jump_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst && rdy && w_push) begin
            r_q_ins[r_tail] <= mem_data_i;
            r_q_pc[r_tail]  <= r_fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0;
            r_fetch_pc <= RESET_PC;
            r_drop     <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (rdy) begin
            if (redirect_i) begin
                r_count    <= '0;
                r_head     <= r_tail;
                r_fetch_pc <= redirect_pc_i;
                // An in-flight request cannot be cancelled; its response must be swallowed.
                if (r_state == WAIT && !mem_valid_i) begin
                    r_drop <= 1'b1;
                end else begin
                    r_drop     <= 1'b0;
                    r_state    <= IDLE;
                    r_mem_req  <= 1'b0;
                    r_mem_addr <= 32'h0;
                end
            end else begin
                if (w_push)
                    r_tail <= r_tail + 1'b1;
                if (w_pop)
                    r_head <= r_head + 1'b1;
                if (w_push && !w_pop)
                    r_count <= r_count + 1'b1;
                else if (!w_push && w_pop)
                    r_count <= r_count - 1'b1;

                case (r_state)
                    IDLE: begin
                        if (w_space) begin
                            r_state    <= WAIT;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_fetch_pc;
                        end
                    end
                    WAIT: begin
                        if (mem_valid_i) begin
                            r_state    <= IDLE;
                            r_mem_req  <= 1'b0;
                            r_mem_addr <= 32'h0;
                            if (r_drop)
                                r_drop <= 1'b0;
                            else
                                r_fetch_pc <= w_next_pc;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: cycle vector table for basic fetch, scoreboard on the instruction stream,
// hand-written sequences for full queue, redirect, JAL and rdy freeze.
module tb_fetch_queue_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_data_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        ins_ready_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        ins_valid_o;
    logic [31:0] ins_o;
    logic [31:0] pc_o;
    logic        pred_jump_o;

`ifdef IFQ_JAL_PRED_EN
    localparam logic [31:0] JAL_NEXT = 32'h30;
    localparam logic        JAL_PRED = 1'b1;
`else
    localparam logic [31:0] JAL_NEXT = 32'h24;
    localparam logic        JAL_PRED = 1'b0;
`endif

    always #5 clk = ~clk;

    fetch_queue_unit #(.QDEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .ins_valid_o(ins_valid_o), .ins_ready_i(ins_ready_i),
        .ins_o(ins_o), .pc_o(pc_o), .pred_jump_o(pred_jump_o)
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        pred;
    } exp_t;

    typedef struct {
        logic        mv;
        logic [31:0] md;
        logic        sbp;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    exp_t sb[$];
    vec_t tv[10];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    function automatic vec_t mk(input logic mv, input logic [31:0] md, input logic sbp,
                                input logic req, input logic [31:0] addr,
                                input logic vld, input logic [31:0] pc);
        vec_t v;
        v.mv = mv; v.md = md; v.sbp = sbp; v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
        return v;
    endfunction

    // Handshake monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && rdy && !redirect_i && ins_valid_o && ins_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", {31'd0, ins_valid_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pop_ins", ins_o, e.ins);
                chk("pop_pc", pc_o, e.pc);
                chk("pop_pred", {31'd0, pred_jump_o}, {31'd0, e.pred});
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; mem_valid_i = 1'b0; redirect_i = 1'b0; ins_ready_i = 1'b0;
        sb.delete();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(output logic [31:0] a);
        int i = 0;
        while (!mem_req_o && i < 60) begin
            tick();
            i++;
        end
        chk("req_timeout", {31'd0, mem_req_o}, 32'd1);
        a = mem_addr_o;
    endtask

    // Latency-2 response to the current request.
    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] data,
                         input logic deliver, input logic pred);
        logic [31:0] a;
        wait_req(a);
        chk("serve_addr", a, exp_addr);
        tick();
        mem_valid_i = 1'b1;
        mem_data_i  = data;
        if (deliver) sb.push_back('{data, exp_addr, pred});
        tick();
        mem_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int i = 0;
        ins_ready_i = 1'b1;
        while (sb.size() != 0 && i < 60) begin
            tick();
            i++;
        end
        chk(name, sb.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic        seen;

        tv[0] = mk(0, 0,            0, 1, 32'h0, 0, 32'h0);
        tv[1] = mk(0, 0,            0, 1, 32'h0, 0, 32'h0);
        tv[2] = mk(1, word_at(0),   1, 0, 32'h0, 1, 32'h0);
        tv[3] = mk(0, 0,            0, 1, 32'h4, 0, 32'h0);
        tv[4] = mk(0, 0,            0, 1, 32'h4, 0, 32'h0);
        tv[5] = mk(1, word_at(4),   1, 0, 32'h0, 1, 32'h4);
        tv[6] = mk(0, 0,            0, 1, 32'h8, 0, 32'h0);
        tv[7] = mk(0, 0,            0, 1, 32'h8, 0, 32'h0);
        tv[8] = mk(1, word_at(8),   1, 0, 32'h0, 1, 32'h8);
        tv[9] = mk(0, 0,            0, 1, 32'hC, 0, 32'h0);

        // Reset state and basic latency-2 fetch stream
        do_reset();
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_valid", {31'd0, ins_valid_o}, 32'd0);
        chk("rst_ins", ins_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_pred", {31'd0, pred_jump_o}, 32'd0);
        ins_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            mem_valid_i = tv[k].mv;
            mem_data_i  = tv[k].md;
            if (tv[k].sbp) sb.push_back('{tv[k].md, tv[k].pc, 1'b0});
            tick();
            chk($sformatf("v%0d_req", k), {31'd0, mem_req_o}, {31'd0, tv[k].req});
            chk($sformatf("v%0d_addr", k), mem_addr_o, tv[k].addr);
            chk($sformatf("v%0d_valid", k), {31'd0, ins_valid_o}, {31'd0, tv[k].vld});
            chk($sformatf("v%0d_pc", k), pc_o, tv[k].pc);
        end
        mem_valid_i = 1'b0;
        drain("t1_drain");

        // Full queue stalls requests; one pop reopens fetching at 16
        do_reset();
        for (int i = 0; i < 4; i++)
            serve(32'(i * 4), word_at(32'(i * 4)), 1'b1, 1'b0);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (mem_req_o) seen = 1'b1;
        end
        chk("t2_no_req_full", {31'd0, seen}, 32'd0);
        chk("t2_valid", {31'd0, ins_valid_o}, 32'd1);
        chk("t2_head_pc", pc_o, 32'h0);
        ins_ready_i = 1'b1;
        tick();
        ins_ready_i = 1'b0;
        chk("t2_req_at_pop", {31'd0, mem_req_o}, 32'd0);
        tick();
        chk("t2_req_after_pop", {31'd0, mem_req_o}, 32'd1);
        chk("t2_addr_after_pop", mem_addr_o, 32'h10);
        chk("t2_head_pc_after", pc_o, 32'h4);
        serve(32'h10, word_at(32'h10), 1'b1, 1'b0);
        drain("t2_drain");

        // Redirect while waiting: late response dropped, restart at 0x100
        do_reset();
        serve(32'h0, word_at(32'h0), 1'b0, 1'b0);
        serve(32'h4, word_at(32'h4), 1'b0, 1'b0);
        wait_req(a);
        chk("t3_addr8", a, 32'h8);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        tick();
        redirect_i = 1'b0;
        chk("t3_flush_valid", {31'd0, ins_valid_o}, 32'd0);
        chk("t3_flush_pc", pc_o, 32'h0);
        chk("t3_wait_req", {31'd0, mem_req_o}, 32'd1);
        chk("t3_wait_addr", mem_addr_o, 32'h8);
        tick();
        mem_valid_i = 1'b1;
        mem_data_i  = word_at(32'h8);
        tick();
        mem_valid_i = 1'b0;
        chk("t3_drop_valid", {31'd0, ins_valid_o}, 32'd0);
        chk("t3_drop_req", {31'd0, mem_req_o}, 32'd0);
        tick();
        chk("t3_redir_req", {31'd0, mem_req_o}, 32'd1);
        chk("t3_redir_addr", mem_addr_o, 32'h100);
        ins_ready_i = 1'b1;
        serve(32'h100, word_at(32'h100), 1'b1, 1'b0);
        drain("t3_drain");

        // Redirect coincident with response: discarded, no pending drop
        do_reset();
        ins_ready_i = 1'b1;
        wait_req(a);
        chk("t4_addr0", a, 32'h0);
        tick();
        mem_valid_i = 1'b1;
        mem_data_i  = word_at(32'h0);
        redirect_i  = 1'b1;
        redirect_pc_i = 32'h200;
        tick();
        mem_valid_i = 1'b0;
        redirect_i  = 1'b0;
        chk("t4_valid", {31'd0, ins_valid_o}, 32'd0);
        chk("t4_req_idle", {31'd0, mem_req_o}, 32'd0);
        tick();
        chk("t4_redir_req", {31'd0, mem_req_o}, 32'd1);
        chk("t4_redir_addr", mem_addr_o, 32'h200);
        serve(32'h200, word_at(32'h200), 1'b1, 1'b0);
        drain("t4_drain");
        wait_req(a);
        chk("t4_next_addr", a, 32'h204);

        // JAL at 0x20: followed only when prediction is built in
        do_reset();
        ins_ready_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h20;
        tick();
        redirect_i = 1'b0;
        chk("t5_req_redir_cycle", {31'd0, mem_req_o}, 32'd0);
        serve(32'h20, 32'h0100006F, 1'b1, JAL_PRED);
        chk("t5_valid", {31'd0, ins_valid_o}, 32'd1);
        chk("t5_pred", {31'd0, pred_jump_o}, {31'd0, JAL_PRED});
        wait_req(a);
        chk("t5_next_addr", a, JAL_NEXT);
        drain("t5_drain");

        // rdy low mid-WAIT freezes everything, including pops
        do_reset();
        serve(32'h0, word_at(32'h0), 1'b1, 1'b0);
        wait_req(a);
        chk("t6_addr4", a, 32'h4);
        rdy = 1'b0;
        ins_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t6_frz%0d_req", i), {31'd0, mem_req_o}, 32'd1);
            chk($sformatf("t6_frz%0d_addr", i), mem_addr_o, 32'h4);
            chk($sformatf("t6_frz%0d_valid", i), {31'd0, ins_valid_o}, 32'd1);
            chk($sformatf("t6_frz%0d_pc", i), pc_o, 32'h0);
        end
        rdy = 1'b1;
        serve(32'h4, word_at(32'h4), 1'b1, 1'b0);
        drain("t6_drain");
        wait_req(a);
        chk("t6_next_addr", a, 32'h8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
